saber_host_sequencer: RTL and testbench
=======================================

SABER_HOST_SEQUENCER -- requirements
Module: saber_host_sequencer

Interface
REQ-001 SHALL have parameter MAX_INS, default 64, meaning ISA program memory depth in 37-bit instruction words.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 32'd100_000_000, meaning the maximum number of WAIT cycles before a run is aborted.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port rst_n, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port ins_data, input, 37, the instruction word to load.
REQ-006 SHALL have port ins_valid, input, 1, instruction-stream valid.
REQ-007 SHALL have port ins_last, input, 1, marking the final instruction of the program.
REQ-008 SHALL have port ins_ready, output, 1, instruction-stream ready.
REQ-009 SHALL have ports control_low_word and control_high_word, output, 32 each, driving the compute-core wrapper control words.
REQ-010 SHALL have ports dina_ext_low_word and dina_ext_high_word, output, 32 each, driving the wrapper write data.
REQ-011 SHALL have port status, input, 32, the registered wrapper status: bit0 = all-done, bits 31:1 = cycle count.
REQ-012 SHALL have ports busy, output, 1, and done, output, 1; done is a 1-cycle pulse.
REQ-013 SHALL have ports cycle_count, output, 31; timeout, output, 1 (sticky); and err_overflow, output, 1 (sticky).

Function
REQ-014 SHALL implement states IDLE, LOAD, RST, START, SETTLE, WAIT, ABORT.
REQ-015 All outputs SHALL be registered.
REQ-016 SHALL assert ins_ready only in IDLE or LOAD while word index < MAX_INS; an instruction is accepted when ins_valid=1 and ins_ready=1.
REQ-017 The first acceptance in IDLE SHALL clear timeout, err_overflow and cycle_count, set the index to 0, and enter LOAD.
REQ-018 For each acceptance, the following cycle SHALL drive control_low_word = {20'd0, bit11=1, bit10=1, 4'd0, index[5:0]} and {dina_ext_high_word, dina_ext_low_word} = {27'd0, ins_data}; the index then increments.
REQ-019 In any cycle with no acceptance, control_low_word bits 11:10 SHALL be 0, so no write strobe is issued.
REQ-020 Acceptance with ins_last=1 SHALL enter RST after the write cycle.
REQ-021 Acceptance of word MAX_INS-1 with ins_last=0 SHALL set err_overflow and return to IDLE without running.
REQ-022 RST SHALL drive control_high_word = 32'd1 for exactly 2 cycles.
REQ-023 START SHALL drive control_high_word = 32'd2 for exactly 1 cycle; control_high_word SHALL be 0 otherwise.
REQ-024 SETTLE SHALL last 2 cycles, during which status is ignored to cover wrapper status register latency.
REQ-025 WAIT SHALL increment a 32-bit timer each cycle.
REQ-026 In WAIT, status[0]=1 SHALL capture cycle_count <= status[31:1], pulse done for 1 cycle, and return to IDLE.
REQ-027 In WAIT, timer = TIMEOUT_CYCLES-1 with status[0]=0 SHALL set timeout and enter ABORT.
REQ-028 ABORT SHALL drive control_high_word = 32'd1 for 2 cycles, then enter IDLE with no done pulse.
REQ-029 If status[0] goes high on the same cycle the timer reaches its limit, completion SHALL win.
REQ-030 busy SHALL be 1 in every state except IDLE.
REQ-031 ins_valid in RST through ABORT SHALL be ignored, since ins_ready=0.

Reset
REQ-032 On rst_n=0 at a clk edge: state = IDLE, index and timer = 0, all control and data outputs = 0, ins_ready=0, busy=0, done=0, cycle_count=0, timeout=0, err_overflow=0.
REQ-033 ins_ready SHALL rise on the first cycle after rst_n returns high.
REQ-034 Reset mid-LOAD or mid-WAIT SHALL abandon the operation with no further write strobes or done pulse.

Verification
REQ-035 Load 3 words (A, B, C; last on C) -> writes to addr 0, 1, 2 with control_low_word = 0xC00, 0xC01, 0xC02; then high=1 for 2 cycles, high=2 for 1 cycle.
REQ-036 After start, the model drives status = {31'd5000, 1'b1} -> done pulses once, cycle_count = 5000, busy=0.
REQ-037 With TIMEOUT_CYCLES=16, status held at 0 -> timeout=1 after 16 WAIT cycles, high=1 for 2 cycles, no done pulse.
REQ-038 Stream 64 words with no ins_last -> 64 writes, err_overflow=1, no RST or START issued, ins_ready low after word 64.
REQ-039 ins_valid toggling at random with ins_last on word 10 -> exactly 10 writes, addresses 0..9 contiguous, data matches.
REQ-040 rst_n=0 during WAIT -> next cycle all outputs = 0 and state IDLE; a subsequent 1-word program runs normally.

Source files
------------

// File: rtl/saber_host_sequencer.sv
// saber_host_sequencer
//   Host-side sequencer for the Saber compute-core wrapper. It streams an
//   instruction program into the wrapper's program memory, pulses the core
//   reset, issues a start, waits for the all-done status bit (bounded by a
//   timeout) and reports the core's cycle count.
//
// Ports
//   clk, rst_n              single clock; synchronous active-low reset
//   ins_data/valid/last     instruction stream in (37-bit words)
//   ins_ready               instruction stream ready
//   control_low_word        program-memory write strobe (bits 11:10) + address
//   control_high_word       1 = core reset, 2 = core start, 0 = idle
//   dina_ext_low/high_word  program-memory write data
//   status                  wrapper status: bit0 all-done, bits 31:1 cycle count
//   busy, done              run in progress / 1-cycle completion pulse
//   cycle_count             core cycle count captured at completion
//   timeout, err_overflow   sticky error flags, cleared by the next program
module saber_host_sequencer #(
    parameter int          MAX_INS        = 64,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [36:0] ins_data,
    input  logic        ins_valid,
    input  logic        ins_last,
    output logic        ins_ready,
    output logic [31:0] control_low_word,
    output logic [31:0] control_high_word,
    output logic [31:0] dina_ext_low_word,
    output logic [31:0] dina_ext_high_word,
    input  logic [31:0] status,
    output logic        busy,
    output logic        done,
    output logic [30:0] cycle_count,
    output logic        timeout,
    output logic        err_overflow
);

    // Index must be able to hold MAX_INS itself, which marks "memory full".
    localparam int IDX_W = $clog2(MAX_INS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, RST, START, SETTLE, WAIT, ABORT} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [31:0]        timer_q, timer_d;
    logic               phase_q, phase_d;     // second cycle of 2-cycle states
    logic               ins_ready_q, ins_ready_d;
    logic [31:0]        ctrl_lo_q, ctrl_lo_d;
    logic [31:0]        ctrl_hi_q, ctrl_hi_d;
    logic [31:0]        dina_lo_q, dina_lo_d;
    logic [31:0]        dina_hi_q, dina_hi_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [30:0]        cycle_count_q, cycle_count_d;
    logic               timeout_q, timeout_d;
    logic               err_overflow_q, err_overflow_d;

    logic               accept;
    logic [IDX_W-1:0]   wr_idx;

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        timer_d        = timer_q;
        phase_d        = phase_q;
        ctrl_lo_d      = 32'd0;
        ctrl_hi_d      = 32'd0;
        dina_lo_d      = 32'd0;
        dina_hi_d      = 32'd0;
        done_d         = 1'b0;
        cycle_count_d  = cycle_count_q;
        timeout_d      = timeout_q;
        err_overflow_d = err_overflow_q;

        accept = ins_valid && ins_ready_q;
        // A new program always starts at address 0, whatever the old index.
        wr_idx = (state_q == IDLE) ? '0 : idx_q;

        // Control outputs are decided from the current state and appear one
        // cycle later, so the last write cycle precedes the first reset cycle.
        case (state_q)
            IDLE: begin
                idx_d = '0;
                if (accept) begin
                    timeout_d      = 1'b0;
                    err_overflow_d = 1'b0;
                    cycle_count_d  = '0;
                end
            end
            RST, ABORT: begin
                ctrl_hi_d = 32'd1;
                phase_d   = ~phase_q;
                if (phase_q) begin
                    state_d = (state_q == RST) ? START : IDLE;
                end
            end
            START: begin
                ctrl_hi_d = 32'd2;
                phase_d   = 1'b0;
                state_d   = SETTLE;
            end
            SETTLE: begin
                // Status is stale here: the wrapper registers it.
                phase_d = ~phase_q;
                if (phase_q) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                // Completion is tested first so it wins over the timeout.
                if (status[0]) begin
                    cycle_count_d = status[31:1];
                    done_d        = 1'b1;
                    state_d       = IDLE;
                end else if (timer_q == TIMEOUT_CYCLES - 32'd1) begin
                    timeout_d = 1'b1;
                    phase_d   = 1'b0;
                    state_d   = ABORT;
                end else begin
                    timer_d = timer_q + 32'd1;
                end
            end
            default: ;
        endcase

        // Acceptance is only possible in IDLE/LOAD since ready is low elsewhere.
        if (accept) begin
            ctrl_lo_d              = {20'd0, 2'b11, 4'd0, 6'(wr_idx)};
            {dina_hi_d, dina_lo_d} = {27'd0, ins_data};
            idx_d                  = wr_idx + IDX_W'(1);
            if (ins_last) begin
                phase_d = 1'b0;
                state_d = RST;
            end else if (wr_idx == IDX_W'(MAX_INS - 1)) begin
                err_overflow_d = 1'b1;
                state_d        = IDLE;
            end else begin
                state_d = LOAD;
            end
        end

        // After an overflow the index sits at MAX_INS, holding ready low for
        // one cycle; IDLE then rewinds the index and ready returns.
        busy_d      = (state_d != IDLE);
        ins_ready_d = ((state_d == IDLE) || (state_d == LOAD)) &&
                      (idx_d < IDX_W'(MAX_INS));
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge value of every other flop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            idx_q          <= '0;
            timer_q        <= '0;
            phase_q        <= 1'b0;
            ins_ready_q    <= 1'b0;
            ctrl_lo_q      <= '0;
            ctrl_hi_q      <= '0;
            dina_lo_q      <= '0;
            dina_hi_q      <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            cycle_count_q  <= '0;
            timeout_q      <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            timer_q        <= timer_d;
            phase_q        <= phase_d;
            ins_ready_q    <= ins_ready_d;
            ctrl_lo_q      <= ctrl_lo_d;
            ctrl_hi_q      <= ctrl_hi_d;
            dina_lo_q      <= dina_lo_d;
            dina_hi_q      <= dina_hi_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            cycle_count_q  <= cycle_count_d;
            timeout_q      <= timeout_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign ins_ready          = ins_ready_q;
    assign control_low_word   = ctrl_lo_q;
    assign control_high_word  = ctrl_hi_q;
    assign dina_ext_low_word  = dina_lo_q;
    assign dina_ext_high_word = dina_hi_q;
    assign busy               = busy_q;
    assign done               = done_q;
    assign cycle_count        = cycle_count_q;
    assign timeout            = timeout_q;
    assign err_overflow       = err_overflow_q;

endmodule

// File: tb/tb_saber_host_sequencer.sv
// Testbench for saber_host_sequencer: table-driven program load and run,
// plus directed sequences for timeout, overflow, random handshakes and reset.
module tb_saber_host_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [36:0] ins_data;
    logic        ins_valid;
    logic        ins_last;
    logic        ins_ready;
    logic [31:0] ctrl_lo, ctrl_hi, dina_lo, dina_hi;
    logic [31:0] status;
    logic        busy, done, timeout, err_overflow;
    logic [30:0] cycle_count;

    always #5 clk = ~clk;

    saber_host_sequencer #(.MAX_INS(64), .TIMEOUT_CYCLES(32'd16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .ins_data          (ins_data),
        .ins_valid         (ins_valid),
        .ins_last          (ins_last),
        .ins_ready         (ins_ready),
        .control_low_word  (ctrl_lo),
        .control_high_word (ctrl_hi),
        .dina_ext_low_word (dina_lo),
        .dina_ext_high_word(dina_hi),
        .status            (status),
        .busy              (busy),
        .done              (done),
        .cycle_count       (cycle_count),
        .timeout           (timeout),
        .err_overflow      (err_overflow)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Write / pulse monitor, sampled on the falling edge.
    typedef struct { logic [5:0] addr; logic [63:0] data; } wr_t;
    wr_t wr_q[$];
    int  done_cnt  = 0;
    int  rst_cnt   = 0;
    int  start_cnt = 0;

    always @(negedge clk) begin
        if (ctrl_lo[11:10] == 2'b11) wr_q.push_back('{ctrl_lo[5:0], {dina_hi, dina_lo}});
        if (done) done_cnt++;
        if (ctrl_hi == 32'd1) rst_cnt++;
        if (ctrl_hi == 32'd2) start_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [36:0] word(input int k);
        return {5'(k + 3), 32'hC0DE_0000 + 32'(k)};
    endfunction

    // Load a 1-word program (ins_last set) and check its write to address 0.
    task automatic load_one(input logic [36:0] d);
        int n = 0;
        while (!ins_ready && n < 10) begin step(); n++; end
        check("load_ready", ins_ready, 1'b1);
        ins_valid = 1'b1; ins_last = 1'b1; ins_data = d;
        step();
        ins_valid = 1'b0; ins_last = 1'b0;
        check("load_lo", ctrl_lo, 64'hC00);
        check("load_dina", {dina_hi, dina_lo}, 64'(d));
    endtask

    // Wait for the start pulse, present completion at once (must be ignored
    // through SETTLE), and check the done pulse lands on the first WAIT cycle.
    task automatic finish_run(input logic [30:0] cc);
        int n = 0;
        while (ctrl_hi !== 32'd2 && n < 20) begin step(); n++; end
        check("start_seen", ctrl_hi, 64'd2);
        status = {cc, 1'b1};
        step(); check("settle_done0", done, 1'b0);
        step(); check("settle_done1", done, 1'b0);
        step();
        check("run_done", done, 1'b1);
        check("run_cc", cycle_count, 64'(cc));
        check("run_busy", busy, 1'b0);
        status = 32'd0;
        step(); check("done_single", done, 1'b0);
    endtask

    typedef struct {
        logic        valid;
        logic        last;
        logic [36:0] data;
        logic [31:0] st;
        logic [31:0] lo;
        logic [31:0] hi;
        logic [63:0] dina;
        logic        busy;
        logic        done;
        logic        ready;
        logic [30:0] cc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [36:0] wa, wb, wc, wd;
        int d0, r0, s0, k, iter, nwr;
        logic rdy;

        wa = 37'h01_2345_6789;
        wb = 37'h0A_BCDE_F012;
        wc = 37'h1F_0000_0001;
        wd = 37'h15_5555_5555;
        //           valid last data st                 lo      hi     dina      busy done ready cc
        vecs[0] = '{1'b1, 1'b0, wa, 32'd0,             32'hC00, 32'd0, 64'(wa), 1'b1, 1'b0, 1'b1, 31'd0};
        vecs[1] = '{1'b1, 1'b0, wb, 32'd0,             32'hC01, 32'd0, 64'(wb), 1'b1, 1'b0, 1'b1, 31'd0};
        vecs[2] = '{1'b1, 1'b1, wc, 32'd0,             32'hC02, 32'd0, 64'(wc), 1'b1, 1'b0, 1'b0, 31'd0};
        vecs[3] = '{1'b1, 1'b0, wd, 32'd0,             32'd0,   32'd1, 64'd0,   1'b1, 1'b0, 1'b0, 31'd0};
        vecs[4] = '{1'b1, 1'b1, wd, 32'd0,             32'd0,   32'd1, 64'd0,   1'b1, 1'b0, 1'b0, 31'd0};
        vecs[5] = '{1'b1, 1'b0, wd, 32'd0,             32'd0,   32'd2, 64'd0,   1'b1, 1'b0, 1'b0, 31'd0};
        vecs[6] = '{1'b0, 1'b0, '0, {31'd7, 1'b1},     32'd0,   32'd0, 64'd0,   1'b1, 1'b0, 1'b0, 31'd0};
        vecs[7] = '{1'b0, 1'b0, '0, {31'd7, 1'b1},     32'd0,   32'd0, 64'd0,   1'b1, 1'b0, 1'b0, 31'd0};
        vecs[8] = '{1'b0, 1'b0, '0, {31'd5000, 1'b1},  32'd0,   32'd0, 64'd0,   1'b0, 1'b1, 1'b1, 31'd5000};
        vecs[9] = '{1'b0, 1'b0, '0, 32'd0,             32'd0,   32'd0, 64'd0,   1'b0, 1'b0, 1'b1, 31'd5000};

        // Reset, with valid held high to show ready stays low.
        rst_n = 1'b0; ins_valid = 1'b1; ins_last = 1'b0; ins_data = wd; status = 32'd0;
        step(); step();
        check("rst_ready", ins_ready, 1'b0);
        check("rst_lo", ctrl_lo, 64'd0);
        check("rst_hi", ctrl_hi, 64'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_flags", {done, timeout, err_overflow, cycle_count}, 64'd0);
        rst_n = 1'b1; ins_valid = 1'b0;
        step();
        check("ready_after_rst", ins_ready, 1'b1);

        // 3-word program, reset/start sequence and completion.
        for (int i = 0; i < 10; i++) begin
            ins_valid = vecs[i].valid; ins_last = vecs[i].last;
            ins_data = vecs[i].data; status = vecs[i].st;
            step();
            check($sformatf("v%0d_lo", i), ctrl_lo, 64'(vecs[i].lo));
            check($sformatf("v%0d_hi", i), ctrl_hi, 64'(vecs[i].hi));
            check($sformatf("v%0d_dina", i), {dina_hi, dina_lo}, vecs[i].dina);
            check($sformatf("v%0d_busy", i), busy, vecs[i].busy);
            check($sformatf("v%0d_done", i), done, vecs[i].done);
            check($sformatf("v%0d_ready", i), ins_ready, vecs[i].ready);
            check($sformatf("v%0d_cc", i), cycle_count, 64'(vecs[i].cc));
        end
        ins_valid = 1'b0; ins_last = 1'b0; status = 32'd0;

        // Timeout: 16 WAIT cycles with status low, then ABORT.
        d0 = done_cnt;
        load_one(37'h00_0000_00AA);
        repeat (20) step();
        check("to_not_yet", timeout, 1'b0);
        step();
        check("to_set", timeout, 1'b1);
        check("to_busy", busy, 1'b1);
        step(); check("abort_hi0", ctrl_hi, 64'd1);
        step(); check("abort_hi1", ctrl_hi, 64'd1);
        check("abort_idle", busy, 1'b0);
        step(); check("abort_hi_end", ctrl_hi, 64'd0);
        check("to_sticky", timeout, 1'b1);
        check("to_no_done", done_cnt - d0, 64'd0);

        // Completion arriving on the timeout cycle wins.
        load_one(37'h00_0000_00BB);
        check("to_cleared", timeout, 1'b0);
        repeat (20) step();
        status = {31'd77, 1'b1};
        step();
        check("tie_done", done, 1'b1);
        check("tie_timeout", timeout, 1'b0);
        check("tie_cc", cycle_count, 64'd77);
        status = 32'd0;
        step();

        // Overflow: 64 words without ins_last.
        r0 = rst_cnt; s0 = start_cnt;
        for (int i = 0; i < 64; i++) begin
            ins_valid = 1'b1; ins_last = 1'b0; ins_data = {5'(i), 32'hA5A5_0000 | 32'(i)};
            step();
            check($sformatf("ovf_lo%0d", i), ctrl_lo, 64'({20'd0, 2'b11, 4'd0, 6'(i)}));
            check($sformatf("ovf_dina%0d", i), {dina_hi, dina_lo}, 64'({5'(i), 32'hA5A5_0000 | 32'(i)}));
        end
        check("ovf_flag", err_overflow, 1'b1);
        check("ovf_ready_low", ins_ready, 1'b0);
        check("ovf_busy", busy, 1'b0);
        step();
        check("ovf_no_write", ctrl_lo, 64'd0);
        check("ovf_ready_back", ins_ready, 1'b1);
        ins_valid = 1'b0;
        step(); step();
        check("ovf_no_rst", rst_cnt - r0, 64'd0);
        check("ovf_no_start", start_cnt - s0, 64'd0);

        // Reset in the middle of a load.
        ins_valid = 1'b1; ins_data = wa;
        step(); step();
        rst_n = 1'b0;
        step();
        check("rload_lo", ctrl_lo, 64'd0);
        check("rload_busy", busy, 1'b0);
        check("rload_ovf", err_overflow, 1'b0);
        rst_n = 1'b1;
        ins_valid = 1'b0;
        step();
        check("rload_lo2", ctrl_lo, 64'd0);
        check("rload_ready", ins_ready, 1'b1);

        // Random valid gaps, ins_last on the 10th word.
        step();
        wr_q.delete();
        k = 0; iter = 0;
        while (k < 10 && iter < 200) begin
            ins_valid = 1'($urandom_range(0, 1));
            ins_data  = word(k);
            ins_last  = (k == 9);
            rdy = ins_ready;
            step();
            if (ins_valid && rdy) k++;
            iter++;
        end
        ins_valid = 1'b0; ins_last = 1'b0;
        check("rnd_words_sent", k, 64'd10);
        step();
        nwr = wr_q.size();
        check("rnd_nwrites", nwr, 64'd10);
        for (int i = 0; i < 10 && i < nwr; i++) begin
            check($sformatf("rnd_addr%0d", i), wr_q[i].addr, 64'(i));
            check($sformatf("rnd_data%0d", i), wr_q[i].data, 64'(word(i)));
        end
        check("rnd_ovf_clear", err_overflow, 1'b0);
        finish_run(31'd4242);

        // Reset while waiting for completion, then a fresh 1-word run.
        d0 = done_cnt;
        load_one(37'h00_0000_00CC);
        repeat (8) step();
        check("rwait_busy", busy, 1'b1);
        rst_n = 1'b0; status = {31'd99, 1'b1};
        step();
        check("rwait_hi", ctrl_hi, 64'd0);
        check("rwait_lo", ctrl_lo, 64'd0);
        check("rwait_busy0", busy, 1'b0);
        check("rwait_cc", cycle_count, 64'd0);
        check("rwait_ready", ins_ready, 1'b0);
        rst_n = 1'b1; status = 32'd0;
        step();
        check("rwait_ready1", ins_ready, 1'b1);
        step();
        check("rwait_no_done", done_cnt - d0, 64'd0);
        load_one(37'h1E_DEAD_BEEF);
        finish_run(31'd123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
